ppu_palette_ram: RTL and testbench

Palette memory and pixel-lookup stage of the PPU, directly upstream of the system palette converter. It holds 32 six-bit colour entries (4 background + 4 sprite palettes × 4 entries) written by the CPU. It maps each rendered pixel's palette/index selection, with NES-style backdrop mirroring, to a 6-bit RRGGBB colour code for the system palette. The lookup is a fixed 2-cycle pipeline.

---
 rtl/ppu_palette_ram.sv | 192 +++++++++++++++++++
 tb/tb_ppu_palette_ram.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_palette_ram.sv
// ---------------------------------------------------------------------------
// ppu_palette_ram
//
// Palette memory and pixel-lookup stage of the PPU. It holds 32 six-bit
// colour entries written by the CPU: 4 background palettes followed by
// 4 sprite palettes, with 4 entries each. It turns each rendered pixel's
// {sprite, palette, index} selection into a 6-bit RRGGBB code for the
// system palette stage. The lookup is a fixed two-register pipeline.
//
// Optional feature macro: PALETTE_READBACK_EN
//   defined   : CPU readback through cpu_re / cpu_rdata / cpu_rvalid.
//   undefined : cpu_re is ignored. cpu_rdata is tied to 6'h00 and
//               cpu_rvalid to 0. The ports stay in place.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   cpu_addr     in   5  palette entry address (mirrored, see map_addr)
//   cpu_wdata    in   6  colour code to write {RR,GG,BB}
//   cpu_we       in   1  write strobe, one entry per cycle
//   cpu_re       in   1  read strobe (readback build only)
//   cpu_rdata    out  6  readback data, held between reads
//   cpu_rvalid   out  1  one-cycle pulse qualifying cpu_rdata
//   pix_valid    in   1  pixel request this cycle
//   pix_blank    in   1  pixel lies in blanking
//   pix_sprite   in   1  1 = sprite palettes (16-31), 0 = background (0-15)
//   pix_palette  in   2  palette number
//   pix_index    in   2  colour index, 0 = transparent (backdrop)
//   color_valid  out  1  qualifies color
//   color        out  6  colour code to the system palette stage
// ---------------------------------------------------------------------------
module ppu_palette_ram (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] cpu_addr,
    input  logic [5:0] cpu_wdata,
    input  logic       cpu_we,
    input  logic       cpu_re,
    output logic [5:0] cpu_rdata,
    output logic       cpu_rvalid,
    input  logic       pix_valid,
    input  logic       pix_blank,
    input  logic       pix_sprite,
    input  logic [1:0] pix_palette,
    input  logic [1:0] pix_index,
    output logic       color_valid,
    output logic [5:0] color
);

    localparam logic [5:0] BLANK_COLOR = 6'h00;
    localparam int         NUM_ENTRIES = 32;

    // Sprite entry 0 of each palette (16/20/24/28) is the same physical
    // register as background entry 0 of that palette (0/4/8/12).
    function automatic logic [4:0] map_addr(input logic [4:0] a);
        logic [4:0] m;
        if (a[4] && (a[1:0] == 2'b00)) begin
            m = {1'b0, a[3:0]};
        end else begin
            m = a;
        end
        return m;
    endfunction

    logic [5:0] mem_r [NUM_ENTRIES];

    logic [4:0] wr_addr_s;
    logic [4:0] pix_addr_s;
    logic       bypass_hit_s;
    logic [5:0] color_next_s;

    logic [4:0] s1_addr_r;
    logic       s1_valid_r;
    logic       s1_blank_r;

    logic [5:0] color_r;
    logic       color_valid_r;

    assign wr_addr_s = map_addr(cpu_addr);

    // Pixel address: any transparent index selects the universal backdrop.
    always_comb begin
        pix_addr_s = 5'd0;
        if (pix_index == 2'd0) begin
            pix_addr_s = 5'd0;
        end else begin
            pix_addr_s = {pix_sprite, pix_palette, pix_index};
        end
    end

    // A write landing on the entry being read this edge is forwarded, so the
    // pixel sees the new colour instead of the stale one.
    assign bypass_hit_s = cpu_we && (wr_addr_s == s1_addr_r);

    // Stage-2 colour selection. color holds when no pixel is in stage 1.
    always_comb begin
        color_next_s = color_r;
        if (s1_valid_r) begin
            if (s1_blank_r) begin
                color_next_s = BLANK_COLOR;
            end else if (bypass_hit_s) begin
                color_next_s = cpu_wdata;
            end else begin
                color_next_s = mem_r[s1_addr_r];
            end
        end else begin
            color_next_s = color_r;
        end
    end

    // Palette storage, written by the CPU through the mirror map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_r[i] <= 6'h00;
            end
        end else if (cpu_we) begin
            mem_r[wr_addr_s] <= cpu_wdata;
        end
    end

    // Stage 1: capture the resolved pixel address and its qualifiers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_addr_r  <= 5'd0;
            s1_valid_r <= 1'b0;
            s1_blank_r <= 1'b0;
        end else begin
            s1_addr_r  <= pix_addr_s;
            s1_valid_r <= pix_valid;
            s1_blank_r <= pix_blank;
        end
    end

    // Stage 2: registered colour output to the system palette stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_r       <= 6'h00;
            color_valid_r <= 1'b0;
        end else begin
            color_r       <= color_next_s;
            color_valid_r <= s1_valid_r;
        end
    end

    assign color       = color_r;
    assign color_valid = color_valid_r;

`ifdef PALETTE_READBACK_EN
    logic [5:0] rdata_r;
    logic       rvalid_r;
    logic [5:0] rdata_next_s;

    // Readback and write share cpu_addr. When both strobes are high, the
    // read therefore always targets the entry being written and returns
    // the new data.
    always_comb begin
        rdata_next_s = rdata_r;
        if (cpu_re) begin
            if (cpu_we) begin
                rdata_next_s = cpu_wdata;
            end else begin
                rdata_next_s = mem_r[wr_addr_s];
            end
        end else begin
            rdata_next_s = rdata_r;
        end
    end

    // Readback register: data holds between reads, valid pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r  <= 6'h00;
            rvalid_r <= 1'b0;
        end else begin
            rdata_r  <= rdata_next_s;
            rvalid_r <= cpu_re;
        end
    end

    assign cpu_rdata  = rdata_r;
    assign cpu_rvalid = rvalid_r;
`else
    // Readback not built: the strobe is intentionally left unconnected.
    logic unused_cpu_re_s;
    assign unused_cpu_re_s = cpu_re;

    assign cpu_rdata  = 6'h00;
    assign cpu_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_palette_ram.sv
module tb_ppu_palette_ram;

    logic       clk;
    logic       rst_n;
    logic [4:0] cpu_addr;
    logic [5:0] cpu_wdata;
    logic       cpu_we;
    logic       cpu_re;
    logic [5:0] cpu_rdata;
    logic       cpu_rvalid;
    logic       pix_valid;
    logic       pix_blank;
    logic       pix_sprite;
    logic [1:0] pix_palette;
    logic [1:0] pix_index;
    logic       color_valid;
    logic [5:0] color;

    int check_cnt;
    int error_cnt;

    ppu_palette_ram dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_we      (cpu_we),
        .cpu_re      (cpu_re),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .pix_valid   (pix_valid),
        .pix_blank   (pix_blank),
        .pix_sprite  (pix_sprite),
        .pix_palette (pix_palette),
        .pix_index   (pix_index),
        .color_valid (color_valid),
        .color       (color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [5:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic pix_req(input logic spr, input logic [1:0] pal, input logic [1:0] idx,
                           input logic blank);
        pix_valid   = 1'b1;
        pix_sprite  = spr;
        pix_palette = pal;
        pix_index   = idx;
        pix_blank   = blank;
    endtask

    task automatic pix_idle();
        pix_valid = 1'b0;
        pix_blank = 1'b0;
    endtask

    initial begin
        check_cnt   = 0;
        error_cnt   = 0;
        rst_n       = 1'b0;
        cpu_addr    = 5'd0;
        cpu_wdata   = 6'h00;
        cpu_we      = 1'b0;
        cpu_re      = 1'b0;
        pix_valid   = 1'b0;
        pix_blank   = 1'b0;
        pix_sprite  = 1'b0;
        pix_palette = 2'd0;
        pix_index   = 2'd0;

        tick();
        tick();
        check_eq("rst_color", color, 6'h00);
        check_eq("rst_cvalid", {5'd0, color_valid}, 6'd0);
        check_eq("rst_rdata", cpu_rdata, 6'h00);
        check_eq("rst_rvalid", {5'd0, cpu_rvalid}, 6'd0);
        rst_n = 1'b1;
        tick();

        // Lookup after reset: two-cycle latency, colour 00.
        pix_req(1'b0, 2'd1, 2'd2, 1'b0);
        tick();
        pix_idle();
        check_eq("lat1_cvalid", {5'd0, color_valid}, 6'd0);
        tick();
        check_eq("lat2_cvalid", {5'd0, color_valid}, 6'd1);
        check_eq("lat2_color", color, 6'h00);
        tick();
        check_eq("lat3_cvalid", {5'd0, color_valid}, 6'd0);

        // Write addr 5, then back-to-back backdrop and {0,1,1} lookups.
        cpu_write(5'd5, 6'h30);
        pix_req(1'b1, 2'd3, 2'd0, 1'b0);
        tick();
        pix_req(1'b0, 2'd1, 2'd1, 1'b0);
        tick();
        pix_idle();
        check_eq("bd_cvalid", {5'd0, color_valid}, 6'd1);
        check_eq("bd_color", color, 6'h00);
        tick();
        check_eq("a5_cvalid", {5'd0, color_valid}, 6'd1);
        check_eq("a5_color", color, 6'h30);
        tick();
        check_eq("hold_cvalid", {5'd0, color_valid}, 6'd0);
        check_eq("hold_color", color, 6'h30);

        // Mirror: write to 16 lands in entry 0.
        cpu_write(5'd16, 6'h0C);
        pix_req(1'b0, 2'd0, 2'd0, 1'b0);
        cpu_re   = 1'b1;
        cpu_addr = 5'd0;
        tick();
        cpu_re = 1'b0;
`ifdef PALETTE_READBACK_EN
        check_eq("mir_rvalid", {5'd0, cpu_rvalid}, 6'd1);
        check_eq("mir_rdata", cpu_rdata, 6'h0C);
`else
        check_eq("norb_rvalid", {5'd0, cpu_rvalid}, 6'd0);
        check_eq("norb_rdata", cpu_rdata, 6'h00);
`endif
        pix_req(1'b1, 2'd3, 2'd0, 1'b0);
        tick();
        pix_idle();
        check_eq("mir_color", color, 6'h0C);
        check_eq("mir_cvalid", {5'd0, color_valid}, 6'd1);
        check_eq("rvalid_drop", {5'd0, cpu_rvalid}, 6'd0);
`ifdef PALETTE_READBACK_EN
        check_eq("rdata_hold", cpu_rdata, 6'h0C);
`endif
        tick();
        check_eq("mir_bd_color", color, 6'h0C);

        // Sprite entries and aliasing of 20 onto 4 (must not disturb others).
        cpu_write(5'd31, 6'h15);
        cpu_write(5'd17, 6'h2A);
        cpu_write(5'd20, 6'h07);
        pix_req(1'b1, 2'd3, 2'd3, 1'b0);
        tick();
        pix_req(1'b1, 2'd0, 2'd1, 1'b0);
        tick();
        check_eq("a31_color", color, 6'h15);
        pix_req(1'b0, 2'd0, 2'd1, 1'b0);
        tick();
        pix_idle();
        check_eq("a17_color", color, 6'h2A);
        tick();
        check_eq("a1_color", color, 6'h00);
`ifdef PALETTE_READBACK_EN
        cpu_re   = 1'b1;
        cpu_addr = 5'd4;
        tick();
        cpu_re = 1'b0;
        check_eq("rb_a4", cpu_rdata, 6'h07);
        // A write and a read to the same mapped entry return the new data.
        cpu_we    = 1'b1;
        cpu_re    = 1'b1;
        cpu_addr  = 5'd24;
        cpu_wdata = 6'h21;
        tick();
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        check_eq("rb_wr_same", cpu_rdata, 6'h21);
        cpu_re   = 1'b1;
        cpu_addr = 5'd8;
        tick();
        cpu_re = 1'b0;
        check_eq("rb_a8", cpu_rdata, 6'h21);
`endif

        // Bypass: write 9 at the same edge that the lookup of 9 reaches stage 2.
        pix_req(1'b0, 2'd2, 2'd1, 1'b0);
        tick();
        pix_idle();
        cpu_we    = 1'b1;
        cpu_addr  = 5'd9;
        cpu_wdata = 6'h3F;
        tick();
        cpu_we = 1'b0;
        check_eq("byp_color", color, 6'h3F);
        check_eq("byp_cvalid", {5'd0, color_valid}, 6'd1);

        // Blanking overrides the stored 3F.
        pix_req(1'b0, 2'd2, 2'd1, 1'b1);
        tick();
        pix_idle();
        tick();
        check_eq("blank_color", color, 6'h00);
        check_eq("blank_cvalid", {5'd0, color_valid}, 6'd1);

        // Write to 2 while 31 is being looked up: independent, then read 2.
        pix_req(1'b1, 2'd3, 2'd3, 1'b0);
        tick();
        pix_req(1'b0, 2'd0, 2'd2, 1'b0);
        cpu_we    = 1'b1;
        cpu_addr  = 5'd2;
        cpu_wdata = 6'h11;
        tick();
        cpu_we = 1'b0;
        pix_idle();
        check_eq("indep_a31", color, 6'h15);
        tick();
        check_eq("indep_a2", color, 6'h11);

        // Reset while two pixels are in flight.
        pix_req(1'b1, 2'd0, 2'd1, 1'b0);
        tick();
        pix_req(1'b0, 2'd1, 2'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_cvalid", {5'd0, color_valid}, 6'd0);
        check_eq("mrst_color", color, 6'h00);
        check_eq("mrst_rvalid", {5'd0, cpu_rvalid}, 6'd0);
        pix_idle();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_cvalid", {5'd0, color_valid}, 6'd0);
            check_eq("post_rst_rvalid", {5'd0, cpu_rvalid}, 6'd0);
        end

        // Every pixel-reachable entry is back to 00.
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 4; p++) begin
                for (int x = 0; x < 4; x++) begin
                    pix_req(s[0], p[1:0], x[1:0], 1'b0);
                    tick();
                    pix_idle();
                    tick();
                    check_eq("scan_cvalid", {5'd0, color_valid}, 6'd1);
                    check_eq("scan_color", color, 6'h00);
                end
            end
        end
`ifdef PALETTE_READBACK_EN
        for (int a = 0; a < 32; a++) begin
            cpu_re   = 1'b1;
            cpu_addr = a[4:0];
            tick();
            cpu_re = 1'b0;
            check_eq("scan_rvalid", {5'd0, cpu_rvalid}, 6'd1);
            check_eq("scan_rdata", cpu_rdata, 6'h00);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
